cic_rate_ctrl: RTL
==================

// Module: cic_rate_ctrl
// PURPOSE
//  Run-time rate controller placed between an AXI-stream source/sink and one cic_interpolator.
//  Accepts rate-change requests and applies them only at a CIC phase boundary:
//  stall input -> drain current phase -> reset CIC with new rate -> optionally mute N outputs -> resume.
//  Prevents mid-phase rate glitches and corrupt integrator state; owns CIC rst and rate pins.
// PARAMETERS
//  WIDTH      16  input sample width (matches CIC WIDTH)
//  OWIDTH     18  CIC output width (CIC REG_WIDTH)
//  RMAX       2   max interpolation rate (matches CIC RMAX)
//  RATE_INIT  2   rate after reset, 1..RMAX
//  MUTE_CNT   0   CIC output beats discarded after each reconfig (0 = none)
// PORTS
//  clk            in   1              clock
//  rst            in   1              sync active-high reset
//  cfg_rate       in   RW             requested rate, RW=$clog2(RMAX+1)
//  cfg_valid      in   1              request valid
//  cfg_ready      out  1              request accepted when valid&ready
//  cfg_done       out  1              1-cycle pulse: new rate live
//  s_tdata        in   WIDTH          upstream samples
//  s_tvalid/s_tready  in/out 1        upstream handshake
//  cic_in_tdata   out  WIDTH          to CIC input_tdata
//  cic_in_tvalid  out  1              to CIC input_tvalid
//  cic_in_tready  in   1              from CIC input_tready
//  cic_rst        out  1              to CIC rst
//  cic_rate       out  RW             to CIC rate (registered)
//  cic_out_tdata  in   OWIDTH         from CIC output_tdata
//  cic_out_tvalid in   1              from CIC output_tvalid
//  cic_out_tready out  1              to CIC output_tready
//  m_tdata        out  OWIDTH         downstream samples
//  m_tvalid/m_tready  out/in 1        downstream handshake
// BEHAVIOUR
//  Reset: state RUN, cic_rate=RATE_INIT, cic_rst=1 (cic_rst = rst | flush), cfg_ready=1, cfg_done=0, pending dropped, mute cnt 0.
//  States: RUN, DRAIN, FLUSH, MUTE.
//  RUN: pass-through (comb): cic_in_* = s_*, s_tready=cic_in_tready, m_*=cic_out_*, cic_out_tready=m_tready.
//   cfg_ready=1 only in RUN. On cfg_valid&cfg_ready: latch clamped rate (0->1, >RMAX->RMAX), go DRAIN.
//   Input beat accepted in same cycle as cfg completes normally (before drain).
//  DRAIN: s_tready=0, cic_in_tvalid=0; output path still passes through.
//   Exit to FLUSH on first cycle cic_in_tready==1 (CIC phase 0, all outputs of last input delivered).
//   Downstream stall holds DRAIN indefinitely; no beat dropped or duplicated.
//  FLUSH: exactly 1 cycle; cic_rst=1, s_tready=0, m_tvalid=0, cic_out_tready=0.
//   cic_rate takes pending value on edge entering FLUSH (stable while cic_rst high).
//   Next: MUTE if MUTE_CNT>0 (load counter=MUTE_CNT), else RUN.
//  MUTE: input passes through as in RUN; each cic_out_tvalid beat consumed with cic_out_tready=1,
//   m_tvalid=0, counter-1; last discarded beat -> RUN.
//  cfg_done: registered 1-cycle pulse on first cycle back in RUN after a reconfig; never after rst alone.
//  Latency: pass-through adds 0 cycles; reconfig = drain time + 1 (+ MUTE_CNT beats).
//  Same-rate request still performs full drain/flush (clears CIC state).
//  rst mid-sequence (any state): abort, pending discarded, RATE_INIT restored, no cfg_done.
// TESTING
//  1 RMAX=4,RATE_INIT=4; rst then s beat 100 -> cic_rate=4, cfg_ready=1, 4 m beats mirror CIC, s_tready low 3 cycles.
//  2 cfg_rate=2 accepted at CIC phase 2/4 -> s_tready=0 until phase 0, cic_rst 1 cycle, cic_rate=2, cfg_done pulse, then 2 outs/input.
//  3 cfg_rate=0 -> cic_rate=1; cfg_rate=7 (RMAX=4) -> cic_rate=4.
//  4 m_tready=0 10 cycles during DRAIN -> stays DRAIN, cic_rst=0, all 4 phase beats delivered after release.
//  5 MUTE_CNT=3: after reconfig first 3 CIC beats consumed with m_tvalid=0, 4th appears on m_*.
//  6 rst asserted in DRAIN -> next cycle RUN, cic_rate=RATE_INIT, cfg_ready=1, cfg_done never pulses.

Source files
------------

// File: rtl/cic_rate_ctrl.sv
// Rate controller wrapped around one CIC interpolator.
// A rate change is applied only on a CIC phase boundary: the input is
// stalled, the current phase drains, the CIC is reset for one cycle with the
// new rate on its rate pins, a configurable number of output beats may be
// muted, and then pass-through resumes.
module cic_rate_ctrl #(
   parameter int WIDTH     = 16,
   parameter int OWIDTH    = 18,
   parameter int RMAX      = 2,
   parameter int RATE_INIT = 2,
   parameter int MUTE_CNT  = 0,
   localparam int RW       = $clog2(RMAX + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [RW-1:0]     cfg_rate,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              cfg_done,
   input  logic [WIDTH-1:0]  s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   output logic [WIDTH-1:0]  cic_in_tdata,
   output logic              cic_in_tvalid,
   input  logic              cic_in_tready,
   output logic              cic_rst,
   output logic [RW-1:0]     cic_rate,
   input  logic [OWIDTH-1:0] cic_out_tdata,
   input  logic              cic_out_tvalid,
   output logic              cic_out_tready,
   output logic [OWIDTH-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready
);

   localparam int MW = (MUTE_CNT > 0) ? $clog2(MUTE_CNT + 1) : 1;
   localparam bit HAS_MUTE = (MUTE_CNT > 0);
   localparam logic [RW-1:0] RATE_MIN_C  = RW'(1);
   localparam logic [RW-1:0] RATE_MAX_C  = RW'(RMAX);
   localparam logic [RW-1:0] RATE_INIT_C = RW'(RATE_INIT);
   localparam logic [MW-1:0] MUTE_LOAD_C = MW'(MUTE_CNT);
   localparam logic [MW-1:0] MUTE_LAST_C = MW'(1);
   localparam logic [MW-1:0] MUTE_ONE_C  = MW'(1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FLUSH = 2'd2,
      ST_MUTE  = 2'd3
   } state_t;

   state_t        state_r;
   state_t        state_n_s;
   logic [RW-1:0] pend_rate_r;
   logic [RW-1:0] rate_r;
   logic [MW-1:0] mute_cnt_r;
   logic          done_r;
   logic          mute_dec_s;

   // Requested rates outside 1..RMAX are folded onto the nearest legal rate.
   function automatic logic [RW-1:0] clamp_rate(input logic [RW-1:0] req);
      logic [RW-1:0] res;
      if (req == '0) begin
         res = RATE_MIN_C;
      end else if (req > RATE_MAX_C) begin
         res = RATE_MAX_C;
      end else begin
         res = req;
      end
      return res;
   endfunction

   // Next-state decode and handshake steering for both stream paths.
   always_comb begin
      state_n_s      = state_r;
      cfg_ready      = 1'b0;
      s_tready       = 1'b0;
      cic_in_tdata   = s_tdata;
      cic_in_tvalid  = 1'b0;
      m_tdata        = cic_out_tdata;
      m_tvalid       = 1'b0;
      cic_out_tready = 1'b0;
      mute_dec_s     = 1'b0;
      case (state_r)
         ST_RUN: begin
            cfg_ready      = 1'b1;
            cic_in_tvalid  = s_tvalid;
            s_tready       = cic_in_tready;
            m_tvalid       = cic_out_tvalid;
            cic_out_tready = m_tready;
            if (cfg_valid) begin
               state_n_s = ST_DRAIN;
            end else begin
               state_n_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // Input is held off; outputs of the last sample keep flowing.
            m_tvalid       = cic_out_tvalid;
            cic_out_tready = m_tready;
            if (cic_in_tready) begin
               state_n_s = ST_FLUSH;
            end else begin
               state_n_s = ST_DRAIN;
            end
         end
         ST_FLUSH: begin
            if (HAS_MUTE) begin
               state_n_s = ST_MUTE;
            end else begin
               state_n_s = ST_RUN;
            end
         end
         ST_MUTE: begin
            // Fresh samples may enter; early CIC outputs are swallowed.
            cic_in_tvalid  = s_tvalid;
            s_tready       = cic_in_tready;
            cic_out_tready = 1'b1;
            if (cic_out_tvalid) begin
               mute_dec_s = 1'b1;
               if (mute_cnt_r == MUTE_LAST_C) begin
                  state_n_s = ST_RUN;
               end else begin
                  state_n_s = ST_MUTE;
               end
            end else begin
               state_n_s = ST_MUTE;
            end
         end
         default: begin
            state_n_s = ST_RUN;
         end
      endcase
   end

   // State register, pending/live rate, mute counter and done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_RUN;
         pend_rate_r <= RATE_INIT_C;
         rate_r      <= RATE_INIT_C;
         mute_cnt_r  <= '0;
         done_r      <= 1'b0;
      end else begin
         state_r <= state_n_s;
         if (state_r == ST_RUN && cfg_valid) begin
            pend_rate_r <= clamp_rate(cfg_rate);
         end
         // Rate changes only on the edge into FLUSH, so it is stable under cic_rst.
         if (state_r == ST_DRAIN && state_n_s == ST_FLUSH) begin
            rate_r <= pend_rate_r;
         end
         if (state_r == ST_FLUSH) begin
            mute_cnt_r <= MUTE_LOAD_C;
         end else if (mute_dec_s) begin
            mute_cnt_r <= mute_cnt_r - MUTE_ONE_C;
         end
         done_r <= (state_n_s == ST_RUN) &&
                   (state_r == ST_FLUSH || state_r == ST_MUTE);
      end
   end

   assign cic_rst  = rst | (state_r == ST_FLUSH);
   assign cic_rate = rate_r;
   assign cfg_done = done_r;

endmodule
